wb_unit: RTL

Writeback stage driving the register file's write port (`wb`, `dst`, `reg_write`). It merges results from the ALU path and the load path and performs byte/halfword selection and extension on load data. It buffers ALU results in a 2-entry FIFO when a load claims the port, and keeps a busy scoreboard of registers with results still in flight. Sits between execute/memory stages and the register file; `busy` feeds decode hazard detection.

---
 rtl/wb_unit_if.sv | 37 +++
 rtl/wb_unit.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/wb_unit_if.sv
// Bundle of execute/memory-side result buses and register-file write port
// that the writeback unit sits between.
interface wb_unit_if;
  logic        alu_valid;
  logic [4:0]  alu_dst;
  logic [31:0] alu_data;
  logic        alu_ready;

  logic        ld_valid;
  logic [4:0]  ld_dst;
  logic [31:0] ld_data;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_off;

  logic        iss_valid;
  logic [4:0]  iss_dst;

  logic [31:0] wb;
  logic [4:0]  dst;
  logic        reg_write;
  logic [31:0] busy;

  // Upstream stages and decode drive results and issues; they observe the write port.
  modport master (
    output alu_valid, alu_dst, alu_data,
    output ld_valid, ld_dst, ld_data, ld_funct3, ld_off,
    output iss_valid, iss_dst,
    input  alu_ready, wb, dst, reg_write, busy
  );

  modport slave (
    input  alu_valid, alu_dst, alu_data,
    input  ld_valid, ld_dst, ld_data, ld_funct3, ld_off,
    input  iss_valid, iss_dst,
    output alu_ready, wb, dst, reg_write, busy
  );
endinterface

// File: rtl/wb_unit.sv
// Writeback stage: arbitrates load vs. ALU results onto the register-file write
// port, extends load data, buffers displaced ALU results and tracks pending writes.
module wb_unit #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic      CLOCK_50,
  input  logic      rst_n,
  wb_unit_if.slave  wb_bus
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } ld_funct3_e;

  // ALU result buffer
  logic [4:0]       r_fifo_dst  [FIFO_DEPTH];
  logic [31:0]      r_fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;

  // Register-file write port and scoreboard
  logic [31:0] r_wb;
  logic [4:0]  r_dst;
  logic        r_reg_write;
  logic [31:0] r_busy;

  logic        w_alu_ready;
  logic        w_alu_accept;
  logic        w_fifo_empty;
  logic        w_push;
  logic        w_pop;
  logic        w_sel_valid;
  logic [4:0]  w_sel_dst;
  logic [31:0] w_sel_data;
  logic        w_do_write;
  logic [7:0]  w_ld_byte;
  logic [15:0] w_ld_half;
  logic [31:0] w_ld_word;
  logic [31:0] w_busy_next;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Readiness looks only at the registered count so it never depends on this cycle's pop.
  assign w_alu_ready  = (r_count < CNT_FULL);
  assign w_alu_accept = wb_bus.alu_valid && w_alu_ready;
  assign w_fifo_empty = (r_count == '0);

  always_comb begin
    w_ld_byte = wb_bus.ld_data[7:0];
    case (wb_bus.ld_off)
      2'd0: w_ld_byte = wb_bus.ld_data[7:0];
      2'd1: w_ld_byte = wb_bus.ld_data[15:8];
      2'd2: w_ld_byte = wb_bus.ld_data[23:16];
      2'd3: w_ld_byte = wb_bus.ld_data[31:24];
      default: w_ld_byte = wb_bus.ld_data[7:0];
    endcase
  end

  assign w_ld_half = wb_bus.ld_off[1] ? wb_bus.ld_data[31:16] : wb_bus.ld_data[15:0];

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_ld_word = wb_bus.ld_data;
    case (wb_bus.ld_funct3)
      F3_LB:   w_ld_word = {{24{w_ld_byte[7]}}, w_ld_byte};
      F3_LH:   w_ld_word = {{16{w_ld_half[15]}}, w_ld_half};
      F3_LW:   w_ld_word = wb_bus.ld_data;
      F3_LBU:  w_ld_word = {24'd0, w_ld_byte};
      F3_LHU:  w_ld_word = {16'd0, w_ld_half};
      default: w_ld_word = wb_bus.ld_data;
    endcase
  end

  // Port priority: load, then buffered ALU head, then ALU bypass.
  always_comb begin
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_sel_valid = 1'b0;
    w_sel_dst   = 5'd0;
    w_sel_data  = 32'd0;
    if (wb_bus.ld_valid) begin
      w_sel_valid = 1'b1;
      w_sel_dst   = wb_bus.ld_dst;
      w_sel_data  = w_ld_word;
      w_push      = w_alu_accept;
    end else if (!w_fifo_empty) begin
      w_sel_valid = 1'b1;
      w_sel_dst   = r_fifo_dst[r_rd_ptr];
      w_sel_data  = r_fifo_data[r_rd_ptr];
      w_pop       = 1'b1;
      w_push      = w_alu_accept;
    end else if (w_alu_accept) begin
      w_sel_valid = 1'b1;
      w_sel_dst   = wb_bus.alu_dst;
      w_sel_data  = wb_bus.alu_data;
    end
  end

  // Results for x0 are consumed without raising the write enable.
  assign w_do_write = w_sel_valid && (w_sel_dst != 5'd0);

  // NOTE: buffer storage has no reset; r_count alone decides which entries are meaningful.
  always_ff @(posedge CLOCK_50) begin
    if (w_push) begin
      r_fifo_dst[r_wr_ptr]  <= wb_bus.alu_dst;
      r_fifo_data[r_wr_ptr] <= wb_bus.alu_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_wb        <= 32'd0;
      r_dst       <= 5'd0;
      r_reg_write <= 1'b0;
    end else begin
      r_reg_write <= w_do_write;
      if (w_do_write) begin
        r_wb  <= w_sel_data;
        r_dst <= w_sel_dst;
      end
    end
  end

  // A write presented this cycle retires its bit at the edge; a same-edge issue re-arms it.
  always_comb begin
    w_busy_next = r_busy;
    if (r_reg_write) w_busy_next[r_dst] = 1'b0;
    if (wb_bus.iss_valid) w_busy_next[wb_bus.iss_dst] = 1'b1;
    w_busy_next[0] = 1'b0;
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 32'd0;
    end else begin
      r_busy <= w_busy_next;
    end
  end

  assign wb_bus.alu_ready = w_alu_ready;
  assign wb_bus.wb        = r_wb;
  assign wb_bus.dst       = r_dst;
  assign wb_bus.reg_write = r_reg_write;
  assign wb_bus.busy      = r_busy;

  a_no_x0_write: assert property (@(posedge CLOCK_50) disable iff (!rst_n)
    r_reg_write |-> (r_dst != 5'd0));

  a_count_bound: assert property (@(posedge CLOCK_50) disable iff (!rst_n)
    r_count <= CNT_FULL);

  a_busy_x0_clear: assert property (@(posedge CLOCK_50) disable iff (!rst_n)
    !r_busy[0]);

  a_no_push_when_full: assert property (@(posedge CLOCK_50) disable iff (!rst_n)
    (r_count == CNT_FULL) |-> !w_push || w_pop);

endmodule
